// File: rtl/dual_issue_ctrl_pkg.sv
// dual_issue_ctrl_pkg: front-end shared ctrl bit indices and controller state enum
package dual_issue_ctrl_pkg;
    localparam int SW  = 5;
    localparam int LW  = 4;
    localparam int R   = 3;
    localparam int BR  = 2;
    localparam int JMP = 1;
    localparam int HLT = 0;
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;
endpackage

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: two-wide issue register with branch speculation tagging, mispredict flush and halt
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   fetch_valid/fetch_ready         decoded pair handshake; ctrl1/ctrl2 = {sw,lw,r,branch,jmp,hlt}
//   issue_valid/issue_ready         issued pair handshake; issue_slot2_en, spec1, spec2 describe it
//   br_resolve_valid, br_mispredict oldest outstanding branch resolution
//   flush                           one-cycle discard pulse after a mispredict
//   halted, br_cnt                  halt status, outstanding branch count
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int MAX_BR       = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_valid,
    output logic       fetch_ready,
    input  logic [5:0] ctrl1,
    input  logic [5:0] ctrl2,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic       issue_slot2_en,
    output logic       spec1,
    output logic       spec2,
    input  logic       br_resolve_valid,
    input  logic       br_mispredict,
    output logic       flush,
    output logic       halted,
    output logic [2:0] br_cnt
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    state_t        state_q, state_d;
    logic [2:0]    br_cnt_q, br_cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          issue_valid_q, issue_valid_d;
    logic          s2en_q, s2en_d;
    logic          spec1_q, spec1_d;
    logic          spec2_q, spec2_d;
    logic          flush_q, flush_d;
    logic          s2en, mispred, accept;
    logic [1:0]    nbr;
    logic [2:0]    cnt_eff;
    logic          unused;
    assign unused = ^{ctrl1[5:3], ctrl2[5:3], ctrl2[JMP]};
    always_comb begin
        s2en    = !(ctrl1[JMP] | ctrl1[HLT]);
        nbr     = {1'b0, ctrl1[BR]} + {1'b0, ctrl2[BR] & s2en};
        // a correct resolve this cycle frees its slot before the incoming pair is counted
        cnt_eff = br_cnt_q - {2'b0, br_resolve_valid && !br_mispredict && br_cnt_q != 3'd0};
        mispred = br_resolve_valid && br_mispredict && br_cnt_q != 3'd0;
        fetch_ready = state_q == RUN && (!issue_valid_q || issue_ready)
                    && ({1'b0, cnt_eff} + {2'b0, nbr} <= 4'(MAX_BR))
                    && !(br_resolve_valid && br_mispredict);
        accept  = fetch_valid && fetch_ready;
        state_d       = state_q;
        br_cnt_d      = cnt_eff;
        fcnt_d        = fcnt_q;
        flush_d       = 1'b0;
        issue_valid_d = issue_valid_q && !issue_ready;
        s2en_d        = s2en_q;
        spec1_d       = spec1_q;
        spec2_d       = spec2_q;
        if (mispred) begin
            issue_valid_d = 1'b0;
            br_cnt_d      = 3'd0;
            flush_d       = 1'b1;
            fcnt_d        = FW'(FLUSH_CYCLES);
            state_d       = FLUSH;
        end else begin
            if (accept) begin
                issue_valid_d = 1'b1;
                s2en_d        = s2en;
                spec1_d       = cnt_eff != 3'd0;
                spec2_d       = (cnt_eff != 3'd0) | ctrl1[BR];
                br_cnt_d      = cnt_eff + {1'b0, nbr};
                if (ctrl1[HLT] || (ctrl2[HLT] && s2en)) state_d = HALTED;
            end
            if (state_q == FLUSH) begin
                fcnt_d = fcnt_q - FW'(1);
                if (fcnt_q == FW'(1)) state_d = RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            br_cnt_q      <= 3'd0;
            fcnt_q        <= '0;
            issue_valid_q <= 1'b0;
            s2en_q        <= 1'b0;
            spec1_q       <= 1'b0;
            spec2_q       <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            br_cnt_q      <= br_cnt_d;
            fcnt_q        <= fcnt_d;
            issue_valid_q <= issue_valid_d;
            s2en_q        <= s2en_d;
            spec1_q       <= spec1_d;
            spec2_q       <= spec2_d;
            flush_q       <= flush_d;
        end
    end
    assign issue_valid    = issue_valid_q;
    assign issue_slot2_en = s2en_q;
    assign spec1          = spec1_q;
    assign spec2          = spec2_q;
    assign flush          = flush_q;
    assign halted         = state_q == HALTED;
    assign br_cnt         = br_cnt_q;
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb_dual_issue_ctrl: directed test-plan scenarios plus randomized traffic against a scoreboard model
module tb_dual_issue_ctrl;
    localparam int MAXB = 2;
    localparam int FC   = 2;
    localparam logic [5:0] C_R = 6'b001000, C_B = 6'b000100, C_J = 6'b000010, C_H = 6'b000001;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_valid = 1'b0, fetch_ready;
    logic [5:0] ctrl1 = '0, ctrl2 = '0;
    logic       issue_valid, issue_ready = 1'b0, issue_slot2_en, spec1, spec2;
    logic       br_resolve_valid = 1'b0, br_mispredict = 1'b0;
    logic       flush, halted;
    logic [2:0] br_cnt;
    always #5 clk = ~clk;
    dual_issue_ctrl #(.MAX_BR(MAXB), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .ctrl1(ctrl1), .ctrl2(ctrl2), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_slot2_en(issue_slot2_en), .spec1(spec1), .spec2(spec2),
        .br_resolve_valid(br_resolve_valid), .br_mispredict(br_mispredict),
        .flush(flush), .halted(halted), .br_cnt(br_cnt)
    );
    typedef struct packed {logic s2; logic sp1; logic sp2;} exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0;
    int   m_br = 0, m_hold = 0;
    logic m_halt = 1'b0, m_flush = 1'b0, chk_en = 1'b0;
    int   eff, nbr;
    logic s2, rdy, misp, hlt;
    exp_t e;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    // monitor and reference model: compare this cycle, then advance the model past the coming edge
    always @(negedge clk) begin
        s2   = !(ctrl1[1] | ctrl1[0]);
        nbr  = int'(ctrl1[2]) + int'(ctrl2[2] & s2);
        eff  = m_br - ((br_resolve_valid && !br_mispredict && m_br > 0) ? 1 : 0);
        misp = br_resolve_valid && br_mispredict && m_br > 0;
        hlt  = ctrl1[0] | (ctrl2[0] & s2);
        rdy  = !m_halt && m_hold == 0 && (q.size() == 0 || issue_ready)
             && eff + nbr <= MAXB && !(br_resolve_valid && br_mispredict);
        if (chk_en) begin
            chk("fetch_ready", 8'(fetch_ready), 8'(rdy));
            chk("issue_valid", 8'(issue_valid), 8'(q.size() != 0));
            chk("flush", 8'(flush), 8'(m_flush));
            chk("halted", 8'(halted), 8'(m_halt));
            chk("br_cnt", 8'(br_cnt), 8'(m_br));
            if (q.size() != 0) begin
                chk("issue_slot2_en", 8'(issue_slot2_en), 8'(q[0].s2));
                chk("spec1", 8'(spec1), 8'(q[0].sp1));
                chk("spec2", 8'(spec2), 8'(q[0].sp2));
                if (issue_ready) e = q.pop_front();
            end
        end
        if (!rst_n) begin
            q.delete();
            m_br = 0; m_hold = 0; m_halt = 1'b0; m_flush = 1'b0; chk_en = 1'b1;
        end else begin
            m_flush = misp;
            if (misp) begin
                q.delete();
                m_br = 0; m_hold = FC; m_halt = 1'b0;
            end else begin
                if (m_hold > 0) m_hold--;
                m_br = eff;
                if (fetch_valid && rdy) begin
                    q.push_back('{s2: s2, sp1: eff != 0, sp2: (eff != 0) | ctrl1[2]});
                    m_br = eff + nbr;
                    if (hlt) m_halt = 1'b1;
                end
            end
        end
    end
    task automatic cyc(input logic fv, input logic [5:0] a, input logic [5:0] b,
                       input logic ir, input logic rv, input logic mp);
        fetch_valid = fv; ctrl1 = a; ctrl2 = b;
        issue_ready = ir; br_resolve_valid = rv; br_mispredict = mp;
        @(posedge clk);
        #1;
    endtask
    initial begin
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(1, C_R, C_R, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, C_B, C_R, 1, 0, 0);
        cyc(1, C_R, C_R, 1, 0, 0);
        cyc(1, C_B, C_R, 1, 0, 0);
        cyc(1, C_B, C_R, 1, 0, 0);
        cyc(1, C_B, C_R, 1, 1, 0);
        cyc(1, C_R, C_R, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        repeat (4) cyc(1, C_R, C_R, 1, 0, 0);
        cyc(1, C_J, C_B, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, C_B, C_R, 1, 0, 0);
        cyc(1, C_H, C_R, 1, 0, 0);
        repeat (2) cyc(1, C_R, C_R, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        repeat (4) cyc(1, C_R, C_R, 1, 0, 0);
        cyc(1, C_B, C_R, 1, 0, 0);
        cyc(1, C_H, C_R, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, C_R, C_R, 1, 1, 0);
        repeat (2) cyc(1, C_R, C_R, 1, 0, 0);
        rst_n = 1'b0;
        cyc(1, C_R, C_R, 1, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] a, b;
            logic rv;
            a = 6'($urandom) & 6'b111110;
            b = 6'($urandom) & 6'b111110;
            a[0] = $urandom_range(0, 40) == 0;
            b[0] = $urandom_range(0, 40) == 0;
            rv = $urandom_range(0, 9) < 3;
            rst_n = $urandom_range(0, 199) != 0;
            cyc($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 9) < 7, rv,
                rv && $urandom_range(0, 9) < 3);
        end
        cyc(0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
